// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave
// Description : SPI responder with one chip-select. Pins are synchronised into
//               clk; RX bytes come out as pulses, TX bytes go through a
//               one-deep holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave #(
    parameter int         SPI_MODE         = 0,
    parameter int         MAX_BYTES_PER_CS = 2,
    parameter logic [7:0] TX_DEFAULT       = 8'hFF
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  i_SCK,
    input  logic                                  i_CSn,
    input  logic                                  i_MOSI,
    output logic                                  o_MISO,
    output logic                                  o_MISO_OE,
    input  logic [7:0]                            i_TX_Byte,
    input  logic                                  i_TX_DV,
    output logic                                  o_TX_Ready,
    output logic                                  o_TX_Underrun,
    output logic                                  o_RX_DV,
    output logic [7:0]                            o_RX_Byte,
    output logic [$clog2(MAX_BYTES_PER_CS+1)-1:0] o_RX_Count,
    output logic                                  o_CS_Active
);

    localparam int              c_CW   = $clog2(MAX_BYTES_PER_CS + 1);
    localparam logic            c_CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic            c_CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);
    localparam logic [c_CW-1:0] c_MAX  = c_CW'(MAX_BYTES_PER_CS);

    logic [2:0]      r_sck_sync_q,  w_sck_sync_d;
    logic [2:0]      r_csn_sync_q,  w_csn_sync_d;
    logic [1:0]      r_mosi_sync_q, w_mosi_sync_d;
    logic            r_armed_q,     w_armed_d;
    logic [2:0]      r_bit_cnt_q,   w_bit_cnt_d;
    logic [6:0]      r_rx_sh_q,     w_rx_sh_d;
    logic [7:0]      r_rx_byte_q,   w_rx_byte_d;
    logic            r_rx_dv_q,     w_rx_dv_d;
    logic [c_CW-1:0] r_rx_cnt_q,    w_rx_cnt_d;
    logic [c_CW-1:0] r_byte_idx_q,  w_byte_idx_d;
    logic [7:0]      r_tx_sh_q,     w_tx_sh_d;
    logic            r_miso_q,      w_miso_d;
    logic            r_miso_oe_q,   w_miso_oe_d;
    logic            r_cs_act_q,    w_cs_act_d;
    logic [7:0]      r_hold_q,      w_hold_d;
    logic            r_hold_full_q, w_hold_full_d;
    logic            r_underrun_q,  w_underrun_d;

    logic w_cs_act, w_cs_fall, w_cs_rise;
    logic w_lead, w_trail, w_sample, w_shift, w_load;

    // Activity is only honoured once CS has been seen high after reset.
    assign w_cs_act  = r_armed_q & ~r_csn_sync_q[1];
    assign w_cs_fall = r_armed_q & r_csn_sync_q[2] & ~r_csn_sync_q[1];
    assign w_cs_rise = ~r_csn_sync_q[2] & r_csn_sync_q[1];
    assign w_lead    = w_cs_act & (r_sck_sync_q[2] == c_CPOL) & (r_sck_sync_q[1] != c_CPOL);
    assign w_trail   = w_cs_act & (r_sck_sync_q[2] != c_CPOL) & (r_sck_sync_q[1] == c_CPOL);
    assign w_sample  = c_CPHA ? w_trail : w_lead;
    assign w_shift   = c_CPHA ? w_lead  : w_trail;
    assign w_load    = (w_shift & (r_bit_cnt_q == 3'd0)) | (~c_CPHA & w_cs_fall);

    always_comb begin
        w_sck_sync_d  = {r_sck_sync_q[1:0], i_SCK};
        w_csn_sync_d  = {r_csn_sync_q[1:0], i_CSn};
        w_mosi_sync_d = {r_mosi_sync_q[0], i_MOSI};
        w_armed_d     = r_armed_q | r_csn_sync_q[1];
        w_bit_cnt_d   = r_bit_cnt_q;
        w_rx_sh_d     = r_rx_sh_q;
        w_rx_byte_d   = r_rx_byte_q;
        w_rx_dv_d     = 1'b0;
        w_rx_cnt_d    = r_rx_cnt_q;
        w_byte_idx_d  = r_byte_idx_q;
        w_tx_sh_d     = r_tx_sh_q;
        w_miso_d      = r_miso_q;
        w_miso_oe_d   = w_cs_act;
        w_cs_act_d    = w_cs_act;
        w_hold_d      = r_hold_q;
        w_hold_full_d = r_hold_full_q;
        w_underrun_d  = 1'b0;

        if (w_cs_rise) begin
            w_bit_cnt_d = 3'd0;
            w_rx_sh_d   = 7'd0;
            w_tx_sh_d   = 8'd0;
            w_miso_d    = 1'b0;
        end
        if (w_cs_fall) begin
            w_rx_cnt_d   = '0;
            w_byte_idx_d = '0;
        end

        if (w_sample) begin
            w_rx_sh_d   = {r_rx_sh_q[5:0], r_mosi_sync_q[1]};
            w_bit_cnt_d = r_bit_cnt_q + 3'd1;
            if (r_bit_cnt_q == 3'd7) begin
                w_rx_byte_d  = {r_rx_sh_q, r_mosi_sync_q[1]};
                w_rx_dv_d    = 1'b1;
                w_rx_cnt_d   = r_byte_idx_q;
                w_byte_idx_d = (r_byte_idx_q == c_MAX) ? c_MAX : r_byte_idx_q + 1'b1;
            end
        end

        if (w_load) begin
            if (r_hold_full_q) begin
                w_tx_sh_d     = r_hold_q;
                w_hold_full_d = 1'b0;
            end else begin
                w_tx_sh_d    = TX_DEFAULT;
                w_underrun_d = 1'b1;
            end
            w_miso_d = w_tx_sh_d[7];
        end else if (w_shift) begin
            w_tx_sh_d = {r_tx_sh_q[6:0], 1'b0};
            w_miso_d  = r_tx_sh_q[6];
        end

        // A write coinciding with a load point only fills the register after the load saw it empty.
        if (i_TX_DV && !r_hold_full_q) begin
            w_hold_d      = i_TX_Byte;
            w_hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sck_sync_q  <= {3{c_CPOL}};
            // Reads as "CS low" so a CS already held low at release is not a fall.
            r_csn_sync_q  <= 3'b000;
            r_mosi_sync_q <= 2'b00;
            r_armed_q     <= 1'b0;
            r_bit_cnt_q   <= 3'd0;
            r_rx_sh_q     <= 7'd0;
            r_rx_byte_q   <= 8'd0;
            r_rx_dv_q     <= 1'b0;
            r_rx_cnt_q    <= '0;
            r_byte_idx_q  <= '0;
            r_tx_sh_q     <= 8'd0;
            r_miso_q      <= 1'b0;
            r_miso_oe_q   <= 1'b0;
            r_cs_act_q    <= 1'b0;
            r_hold_q      <= 8'd0;
            r_hold_full_q <= 1'b0;
            r_underrun_q  <= 1'b0;
        end else begin
            r_sck_sync_q  <= w_sck_sync_d;
            r_csn_sync_q  <= w_csn_sync_d;
            r_mosi_sync_q <= w_mosi_sync_d;
            r_armed_q     <= w_armed_d;
            r_bit_cnt_q   <= w_bit_cnt_d;
            r_rx_sh_q     <= w_rx_sh_d;
            r_rx_byte_q   <= w_rx_byte_d;
            r_rx_dv_q     <= w_rx_dv_d;
            r_rx_cnt_q    <= w_rx_cnt_d;
            r_byte_idx_q  <= w_byte_idx_d;
            r_tx_sh_q     <= w_tx_sh_d;
            r_miso_q      <= w_miso_d;
            r_miso_oe_q   <= w_miso_oe_d;
            r_cs_act_q    <= w_cs_act_d;
            r_hold_q      <= w_hold_d;
            r_hold_full_q <= w_hold_full_d;
            r_underrun_q  <= w_underrun_d;
        end
    end

    assign o_MISO        = r_miso_q;
    assign o_MISO_OE     = r_miso_oe_q;
    assign o_TX_Ready    = ~r_hold_full_q;
    assign o_TX_Underrun = r_underrun_q;
    assign o_RX_DV       = r_rx_dv_q;
    assign o_RX_Byte     = r_rx_byte_q;
    assign o_RX_Count    = r_rx_cnt_q;
    assign o_CS_Active   = r_cs_act_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave
// Description : Drives all four SPI modes in lockstep from one master and
//               scores RX bytes, MISO bytes and underruns against a byte model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    localparam int         c_H   = 8;
    localparam logic [7:0] c_DEF = 8'hFF;

    logic       clk = 1'b0;
    logic       rstn;
    logic       ph;
    logic       csn;
    logic       mosi;
    logic [7:0] tx_byte;
    logic       tx_dv;
    logic [3:0] sck, miso, oe, ready, ur, rx_dv, cs_act;
    logic [7:0] rx_byte [4];
    logic [1:0] rx_cnt  [4];

    int n_chk  = 0;
    int n_fail = 0;

    logic [9:0] rxq [4][$];
    int         exp_ur [4];
    int         ur_cnt [4];

    logic [7:0] mb  [4];
    logic [7:0] txb [4];
    bit         sup [4];

    always #5 clk = ~clk;

    // CPOL=1 for modes 2 and 3.
    assign sck = {4{ph}} ^ 4'b1100;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(
            .SPI_MODE         (g),
            .MAX_BYTES_PER_CS (2),
            .TX_DEFAULT       (8'hFF)
        ) u_dut (
            .clk           (clk),
            .rstn          (rstn),
            .i_SCK         (sck[g]),
            .i_CSn         (csn),
            .i_MOSI        (mosi),
            .o_MISO        (miso[g]),
            .o_MISO_OE     (oe[g]),
            .i_TX_Byte     (tx_byte),
            .i_TX_DV       (tx_dv),
            .o_TX_Ready    (ready[g]),
            .o_TX_Underrun (ur[g]),
            .o_RX_DV       (rx_dv[g]),
            .o_RX_Byte     (rx_byte[g]),
            .o_RX_Count    (rx_cnt[g]),
            .o_CS_Active   (cs_act[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_h;
        repeat (c_H) @(negedge clk);
    endtask

    function automatic logic [1:0] sat(input int k);
        return (k > 2) ? 2'd2 : 2'(k);
    endfunction

    task automatic wr_tx(input logic [7:0] b);
        chk("tx_ready_before_write", {28'd0, ready}, 32'hF);
        @(negedge clk);
        tx_byte = b;
        tx_dv   = 1'b1;
        @(negedge clk);
        tx_dv   = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("%s_m%0d_outs", tag, m),
                {miso[m], oe[m], ready[m], ur[m], rx_dv[m], cs_act[m]}, 32'b001000);
            chk($sformatf("%s_m%0d_rx", tag, m), {rx_cnt[m], rx_byte[m]}, 32'h0);
        end
    endtask

    // One chip-select session: nb bytes; stop_at>0 ends the session after that many bits.
    task automatic run_cs(input int nb, input int stop_at, input bit do_rst);
        logic [7:0] cap [4];
        bit         stopped;
        int         loads, used;
        stopped = 1'b0;
        if (sup[0]) wr_tx(txb[0]);
        if (stop_at == 0)
            for (int k = 0; k < nb; k++)
                for (int m = 0; m < 4; m++)
                    rxq[m].push_back({sat(k), mb[k]});
        csn = 1'b0;
        wait_h;
        wait_h;
        chk("cs_active_during", {28'd0, cs_act}, 32'hF);
        chk("miso_oe_during", {28'd0, oe}, 32'hF);
        for (int k = 0; k < nb && !stopped; k++) begin
            for (int b = 0; b < 8; b++) begin
                if (stop_at != 0 && k * 8 + b == stop_at) begin
                    stopped = 1'b1;
                    break;
                end
                mosi = mb[k][7-b];
                wait_h;
                cap[0][7-b] = miso[0];
                cap[2][7-b] = miso[2];
                ph = 1'b1;
                wait_h;
                if (b == 3 && k + 1 < nb && sup[k+1]) wr_tx(txb[k+1]);
                cap[1][7-b] = miso[1];
                cap[3][7-b] = miso[3];
                ph = 1'b0;
                wait_h;
            end
            if (!stopped)
                for (int m = 0; m < 4; m++)
                    chk($sformatf("miso_byte%0d_m%0d", k, m), {24'd0, cap[m]},
                        {24'd0, sup[k] ? txb[k] : c_DEF});
        end
        if (do_rst) begin
            #3 rstn = 1'b0;
            #1 chk_reset_vals("async_reset");
            repeat (3) @(negedge clk);
            rstn = 1'b1;
            repeat (12) @(negedge clk);
            chk("cs_low_after_reset_ignored", {28'd0, cs_act | oe}, 32'h0);
            ph  = 1'b0;
            csn = 1'b1;
            repeat (12) @(negedge clk);
            for (int m = 0; m < 4; m++) begin
                rxq[m].delete();
                exp_ur[m] = 0;
                ur_cnt[m] = 0;
            end
            return;
        end
        wait_h;
        csn = 1'b1;
        repeat (12) @(negedge clk);
        chk("miso_oe_after_cs", {28'd0, oe}, 32'h0);
        chk("cs_active_after_cs", {28'd0, cs_act}, 32'h0);
        chk("tx_ready_after_cs", {28'd0, ready}, 32'hF);
        for (int m = 0; m < 4; m++) begin
            // CPHA=0 loads once more on the final shift edge of every completed byte.
            loads = stopped ? 1 : nb + (((m == 0) || (m == 2)) ? 1 : 0);
            used  = 0;
            for (int j = 0; j < loads && j < nb; j++)
                if (sup[j] && !(stopped && j > 0)) used++;
            exp_ur[m] += loads - used;
            chk($sformatf("underruns_m%0d", m), ur_cnt[m], exp_ur[m]);
            chk($sformatf("rx_all_seen_m%0d", m), rxq[m].size(), 0);
        end
    endtask

    initial begin : main
        int nb;
        rstn    = 1'b0;
        ph      = 1'b0;
        csn     = 1'b1;
        mosi    = 1'b0;
        tx_byte = 8'h00;
        tx_dv   = 1'b0;
        for (int m = 0; m < 4; m++) begin
            exp_ur[m] = 0;
            ur_cnt[m] = 0;
        end
        fork
            forever begin
                @(negedge clk);
                for (int m = 0; m < 4; m++) begin
                    if (ur[m]) ur_cnt[m]++;
                    if (rx_dv[m]) begin
                        chk($sformatf("rx_expected_m%0d", m), rxq[m].size() > 0, 1);
                        if (rxq[m].size() > 0)
                            chk($sformatf("rx_m%0d", m), {rx_cnt[m], rx_byte[m]}, rxq[m].pop_front());
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk_reset_vals("in_reset");
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        chk_reset_vals("after_reset");

        mb[0] = 8'h3C; txb[0] = 8'hA5; sup[0] = 1'b1;
        run_cs(1, 0, 1'b0);

        mb[0] = 8'hDE; mb[1] = 8'hAD; txb[0] = 8'h12; txb[1] = 8'h34;
        sup[0] = 1'b1; sup[1] = 1'b1;
        run_cs(2, 0, 1'b0);

        mb[0] = 8'h5A; sup[0] = 1'b0;
        run_cs(1, 0, 1'b0);

        mb[0] = 8'hC3; txb[0] = 8'h77; sup[0] = 1'b1;
        run_cs(1, 5, 1'b0);
        mb[0] = 8'h81; txb[0] = 8'h42; sup[0] = 1'b1;
        run_cs(1, 0, 1'b0);

        mb[0] = 8'h01; mb[1] = 8'h80; mb[2] = 8'hF0;
        txb[0] = 8'h0F; txb[1] = 8'hE7; txb[2] = 8'h00;
        sup[0] = 1'b1; sup[1] = 1'b0; sup[2] = 1'b1;
        run_cs(3, 0, 1'b0);

        mb[0] = 8'h96; txb[0] = 8'h69; sup[0] = 1'b1;
        run_cs(1, 3, 1'b1);
        mb[0] = 8'hB4; mb[1] = 8'h2D; txb[0] = 8'hC8; txb[1] = 8'h13;
        sup[0] = 1'b1; sup[1] = 1'b1;
        run_cs(2, 0, 1'b0);

        for (int t = 0; t < 12; t++) begin
            nb = $urandom_range(1, 4);
            for (int k = 0; k < 4; k++) begin
                mb[k]  = 8'($urandom);
                txb[k] = 8'($urandom);
                sup[k] = 1'($urandom);
            end
            run_cs(nb, 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
